// File: rtl/read_from_fifo_rx_if.sv
// Handshake bundle between the RX FIFO drain and its FIFO/consumer environment.
interface read_from_fifo_rx_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
);
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rdata;
   logic              rd_en;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              ready;
   logic [CNT_W-1:0]  byte_cnt;

   modport master (
      input  fifo_empty, fifo_rdata, ready,
      output rd_en, data_out, data_valid, byte_cnt
   );

   modport slave (
      output fifo_empty, fifo_rdata, ready,
      input  rd_en, data_out, data_valid, byte_cnt
   );
endinterface

// File: rtl/read_from_fifo_rx.sv
// RX FIFO drain: strobes one read, waits RD_LAT cycles, holds the byte on valid/ready (rd_en -> data_valid is RD_LAT+1 cycles).
// Back-pressure: while ready is low the byte is held and no further reads are issued; GAP idle cycles follow each handshake.
module read_from_fifo_rx #(
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1,
   parameter int GAP    = 3,
   parameter int CNT_W  = 16
) (
   input logic                 ckht,
   input logic                 rst,
   read_from_fifo_rx_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);
   localparam logic [3:0] GAP_LAST  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

   state_t            state;
   logic [1:0]        wait_cnt;
   logic [3:0]        gap_cnt;
   logic              rd_en_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  cnt_q;

   always_ff @(posedge ckht or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         gap_cnt  <= '0;
         rd_en_q  <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         cnt_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!bus.fifo_empty) begin
                  state   <= S_READ;
                  rd_en_q <= 1'b1;
               end
            end
            S_READ: begin
               state    <= S_WAIT;
               rd_en_q  <= 1'b0;
               wait_cnt <= '0;
            end
            S_WAIT: begin
               // fifo_rdata is valid only in the last WAIT cycle
               if (wait_cnt == WAIT_LAST) begin
                  data_q  <= bus.fifo_rdata;
                  valid_q <= 1'b1;
                  state   <= S_HOLD;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            S_HOLD: begin
               if (bus.ready) begin
                  valid_q <= 1'b0;
                  cnt_q   <= cnt_q + 1'b1;
                  if (GAP != 0) begin
                     state   <= S_GAP;
                     gap_cnt <= '0;
                  end else if (!bus.fifo_empty) begin
                     state   <= S_READ;
                     rd_en_q <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            default: begin
               state   <= S_IDLE;
               rd_en_q <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_en      = rd_en_q;
   assign bus.data_valid = valid_q;
   assign bus.data_out   = data_q;
   assign bus.byte_cnt   = cnt_q;

endmodule

// File: tb/tb_read_from_fifo_rx.sv
// Directed bench: instance A (RD_LAT=1, GAP=3, CNT_W=4) and instance B (RD_LAT=2, GAP=0, CNT_W=16),
// each fed by a small behavioural FIFO that drives 0xEE on rdata whenever no read data is due.
module tb_read_from_fifo_rx;

   logic ckht;
   logic rst;

   read_from_fifo_rx_if #(.DATA_W(8), .CNT_W(4))  bus_a ();
   read_from_fifo_rx_if #(.DATA_W(8), .CNT_W(16)) bus_b ();

   read_from_fifo_rx #(.DATA_W(8), .RD_LAT(1), .GAP(3), .CNT_W(4)) u_a (
      .ckht (ckht),
      .rst  (rst),
      .bus  (bus_a)
   );

   read_from_fifo_rx #(.DATA_W(8), .RD_LAT(2), .GAP(0), .CNT_W(16)) u_b (
      .ckht (ckht),
      .rst  (rst),
      .bus  (bus_b)
   );

   initial begin
      ckht = 1'b0;
      forever #5 ckht = ~ckht;
   end

   logic [7:0] mem_a [0:31];
   logic [7:0] mem_b [0:31];
   int         wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
   logic [7:0] pa0 = 8'hEE, pb0 = 8'hEE, pb1 = 8'hEE;

   assign bus_a.fifo_empty = (rp_a == wp_a);
   assign bus_a.fifo_rdata = pa0;
   assign bus_b.fifo_empty = (rp_b == wp_b);
   assign bus_b.fifo_rdata = pb1;

   always @(posedge ckht) begin
      if (bus_a.rd_en) rp_a <= rp_a + 1;
      pa0 <= bus_a.rd_en ? mem_a[rp_a % 32] : 8'hEE;
      if (bus_b.rd_en) rp_b <= rp_b + 1;
      pb0 <= bus_b.rd_en ? mem_b[rp_b % 32] : 8'hEE;
      pb1 <= pb0;
   end

   int         nrd_a = 0;
   int         nhs_a = 0;
   logic [7:0] last_a = 8'h00;

   always @(posedge ckht) begin
      if (bus_a.rd_en) nrd_a++;
      if (bus_a.data_valid && bus_a.ready) begin
         nhs_a++;
         last_a = bus_a.data_out;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ckht);
      #1;
   endtask

   task automatic push_a(input logic [7:0] b);
      mem_a[wp_a % 32] = b;
      wp_a = wp_a + 1;
   endtask

   task automatic push_b(input logic [7:0] b);
      mem_b[wp_b % 32] = b;
      wp_b = wp_b + 1;
   endtask

   task automatic wait_hs_a(input int target, input int budget);
      int k = 0;
      while (nhs_a < target && k < budget) begin
         tick();
         k++;
      end
      chk("hs_a_reached", 32'(nhs_a >= target), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit hit before summary");
      $fatal(1);
   end

   initial begin
      int base_hs;
      int base_rd;
      int k;

      rst = 1'b0;
      bus_a.ready = 1'b1;
      bus_b.ready = 1'b1;
      push_a(8'hA5);

      // reset held with a non-empty FIFO and ready high
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_rd_en", 32'(bus_a.rd_en), 32'd0);
         chk("rst_valid", 32'(bus_a.data_valid), 32'd0);
         chk("rst_data", 32'(bus_a.data_out), 32'd0);
         chk("rst_cnt", 32'(bus_a.byte_cnt), 32'd0);
      end
      rst = 1'b1;

      // single byte, GAP=3: rd_en T, valid T+2, next rd_en T+7
      tick();
      chk("t2_rd_T", 32'(bus_a.rd_en), 32'd1);
      chk("t2_valid_T", 32'(bus_a.data_valid), 32'd0);
      tick();
      chk("t2_rd_T1", 32'(bus_a.rd_en), 32'd0);
      chk("t2_valid_T1", 32'(bus_a.data_valid), 32'd0);
      tick();
      chk("t2_valid_T2", 32'(bus_a.data_valid), 32'd1);
      chk("t2_data_T2", 32'(bus_a.data_out), 32'hA5);
      chk("t2_cnt_T2", 32'(bus_a.byte_cnt), 32'd0);
      tick();
      chk("t2_valid_T3", 32'(bus_a.data_valid), 32'd0);
      chk("t2_cnt_T3", 32'(bus_a.byte_cnt), 32'd1);
      chk("t2_data_kept", 32'(bus_a.data_out), 32'hA5);
      push_a(8'h3C);
      bus_a.ready = 1'b0;
      for (int i = 4; i <= 6; i++) begin
         tick();
         chk("t2_gap_no_rd", 32'(bus_a.rd_en), 32'd0);
      end
      tick();
      chk("t2_rd_T7", 32'(bus_a.rd_en), 32'd1);

      // back-pressure: byte 0x3C held for 10 cycles with another byte waiting
      tick();
      tick();
      push_a(8'h77);
      for (int i = 0; i < 10; i++) begin
         chk("t3_valid", 32'(bus_a.data_valid), 32'd1);
         chk("t3_data", 32'(bus_a.data_out), 32'h3C);
         chk("t3_no_rd", 32'(bus_a.rd_en), 32'd0);
         tick();
      end
      chk("t3_cnt_held", 32'(bus_a.byte_cnt), 32'd1);
      bus_a.ready = 1'b1;
      tick();
      chk("t3_cnt_after", 32'(bus_a.byte_cnt), 32'd2);
      chk("t3_valid_after", 32'(bus_a.data_valid), 32'd0);
      for (int i = 0; i < 10; i++) tick();
      chk("t3_cnt_next", 32'(bus_a.byte_cnt), 32'd3);
      chk("t3_data_next", 32'(bus_a.data_out), 32'h77);

      // burst on B, GAP=0, RD_LAT=2: reads every 4 cycles
      for (int i = 1; i <= 4; i++) push_b(8'(i));
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t4_rd", 32'(bus_b.rd_en), 32'd1);
         tick();
         chk("t4_wait1_rd", 32'(bus_b.rd_en), 32'd0);
         chk("t4_wait1_valid", 32'(bus_b.data_valid), 32'd0);
         tick();
         chk("t4_wait2_valid", 32'(bus_b.data_valid), 32'd0);
         tick();
         chk("t4_valid", 32'(bus_b.data_valid), 32'd1);
         chk("t4_data", 32'(bus_b.data_out), 32'(i + 1));
         chk("t4_hold_rd", 32'(bus_b.rd_en), 32'd0);
         tick();
      end
      chk("t4_cnt", 32'(bus_b.byte_cnt), 32'd4);
      chk("t4_end_valid", 32'(bus_b.data_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("t4_idle_rd", 32'(bus_b.rd_en), 32'd0);
         tick();
      end

      // reset with A mid-HOLD and B mid-WAIT
      bus_a.ready = 1'b0;
      push_a(8'h5A);
      k = 0;
      while (!bus_a.data_valid && k < 20) begin
         tick();
         k++;
      end
      chk("t5_a_hold", 32'(bus_a.data_valid), 32'd1);
      chk("t5_a_data", 32'(bus_a.data_out), 32'h5A);
      push_b(8'h99);
      tick();
      chk("t5_b_read", 32'(bus_b.rd_en), 32'd1);
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("t5_a_valid_async", 32'(bus_a.data_valid), 32'd0);
      chk("t5_a_data_async", 32'(bus_a.data_out), 32'd0);
      chk("t5_a_cnt_async", 32'(bus_a.byte_cnt), 32'd0);
      chk("t5_b_rd_async", 32'(bus_b.rd_en), 32'd0);
      chk("t5_b_data_async", 32'(bus_b.data_out), 32'd0);
      chk("t5_b_cnt_async", 32'(bus_b.byte_cnt), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      bus_a.ready = 1'b1;
      base_rd = nrd_a;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_a_no_rd", 32'(bus_a.rd_en), 32'd0);
         chk("t5_b_no_rd", 32'(bus_b.rd_en), 32'd0);
         chk("t5_b_valid", 32'(bus_b.data_valid), 32'd0);
      end
      chk("t5_a_rd_count", 32'(nrd_a - base_rd), 32'd0);

      // 17 handshakes on the 4-bit counter wrap it to 1
      base_hs = nhs_a;
      base_rd = nrd_a;
      for (int i = 0; i < 17; i++) push_a(8'(8'h10 + i));
      wait_hs_a(base_hs + 16, 200);
      chk("t6_wrap_zero", 32'(bus_a.byte_cnt), 32'd0);
      wait_hs_a(base_hs + 17, 200);
      chk("t6_cnt_one", 32'(bus_a.byte_cnt), 32'd1);
      chk("t6_last_byte", 32'(last_a), 32'h20);
      for (int i = 0; i < 8; i++) tick();
      chk("t6_rd_per_byte", 32'(nrd_a - base_rd), 32'd17);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t6_idle_no_rd", 32'(bus_a.rd_en), 32'd0);
      end
      chk("t6_rd_total", 32'(nrd_a - base_rd), 32'd17);
      chk("t6_idle_valid", 32'(bus_a.data_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
